// File: rtl/core_run_control_pkg.sv
// Shared constants for the processor run-control handshake: state encoding and the
// default core/PC geometry used by Processor_Dynamic.
package core_run_control_pkg;

    localparam int unsigned CORE_COUNT_DEF = 32'd2;
    localparam int unsigned REG_WIDTH_DEF  = 32'd12;
    localparam int unsigned CYC_WIDTH_DEF  = 32'd16;
    localparam logic [11:0] CURRENT_PC_VALUE_DEF = 12'b000000000000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        RC_IDLE = ST_IDLE,
        RC_LOAD = ST_LOAD,
        RC_RUN  = ST_RUN,
        RC_DONE = ST_DONE
    } run_state_e;

endpackage

// File: rtl/core_run_control_if.sv
// Start/endop handshake bundle between the external pins / core array and core_run_control.
interface core_run_control_if import core_run_control_pkg::*; #(
    parameter int unsigned core_count = CORE_COUNT_DEF,
    parameter int unsigned reg_width  = REG_WIDTH_DEF,
    parameter int unsigned cyc_width  = CYC_WIDTH_DEF
);
    logic                  start;
    logic [core_count-1:0] core_halt;
    logic                  pc_load;
    logic [reg_width-1:0]  pc_init;
    logic [core_count-1:0] core_run;
    logic [core_count-1:0] endop_signal;
    logic                  all_done;
    logic                  busy;
    logic                  timeout;
    logic [cyc_width-1:0]  cycle_count;

    modport master (
        output start, core_halt,
        input  pc_load, pc_init, core_run, endop_signal, all_done, busy, timeout, cycle_count
    );

    modport slave (
        input  start, core_halt,
        output pc_load, pc_init, core_run, endop_signal, all_done, busy, timeout, cycle_count
    );
endinterface

// File: rtl/core_run_control.sv
// Run-control responder: one start pulse -> PC load, per-core run enables, sticky
// per-core completion, aggregate done, saturating run-cycle count and optional watchdog.
module core_run_control import core_run_control_pkg::*; #(
    parameter int unsigned          core_count       = CORE_COUNT_DEF,
    parameter int unsigned          reg_width        = REG_WIDTH_DEF,
    parameter logic [reg_width-1:0] current_PC_value = reg_width'(CURRENT_PC_VALUE_DEF),
    parameter int unsigned          cyc_width        = CYC_WIDTH_DEF,
    parameter int unsigned          max_cycles       = 32'd0
) (
    input  logic               clk,
    input  logic               reset,
    core_run_control_if.slave  bus
);

    localparam logic [core_count-1:0] ALL_CORES = {core_count{1'b1}};
    localparam logic [core_count-1:0] NO_CORES  = {core_count{1'b0}};
    localparam logic [cyc_width-1:0]  CNT_ZERO  = {cyc_width{1'b0}};
    localparam logic [cyc_width-1:0]  CNT_ONE   = {{(cyc_width-1){1'b0}}, 1'b1};
    localparam logic [cyc_width-1:0]  CNT_MAX   = {cyc_width{1'b1}};
    localparam bit                    WD_EN     = (max_cycles != 32'd0);
    localparam logic [cyc_width-1:0]  WD_LAST   = cyc_width'(max_cycles - 32'd1);

    run_state_e            state_r;
    logic                  pc_load_r;
    logic [core_count-1:0] core_run_r;
    logic [core_count-1:0] endop_r;
    logic                  all_done_r;
    logic                  busy_r;
    logic                  timeout_r;
    logic [cyc_width-1:0]  count_r;

    logic [core_count-1:0] halt_merge_s;
    logic                  all_halted_s;
    logic                  wd_hit_s;
    logic [cyc_width-1:0]  count_inc_s;

    // Halts seen this edge join the already-finished set; the watchdog looks at the pre-edge count.
    assign halt_merge_s = endop_r | bus.core_halt;
    assign all_halted_s = &halt_merge_s;
    assign wd_hit_s     = WD_EN && (count_r == WD_LAST);
    assign count_inc_s  = (count_r == CNT_MAX) ? count_r : (count_r + CNT_ONE);

    // Run-control FSM with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= RC_IDLE;
            pc_load_r  <= 1'b0;
            core_run_r <= NO_CORES;
            endop_r    <= NO_CORES;
            all_done_r <= 1'b0;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
            count_r    <= CNT_ZERO;
        end else begin
            case (state_r)
                RC_IDLE, RC_DONE: begin
                    if (bus.start) begin
                        state_r    <= RC_LOAD;
                        pc_load_r  <= 1'b1;
                        busy_r     <= 1'b1;
                        core_run_r <= NO_CORES;
                        endop_r    <= NO_CORES;
                        all_done_r <= 1'b0;
                        timeout_r  <= 1'b0;
                        count_r    <= CNT_ZERO;
                    end
                end
                RC_LOAD: begin
                    state_r    <= RC_RUN;
                    pc_load_r  <= 1'b0;
                    busy_r     <= 1'b1;
                    core_run_r <= ALL_CORES;
                end
                RC_RUN: begin
                    count_r <= count_inc_s;
                    // A natural finish on the watchdog edge is not reported as a timeout.
                    if (all_halted_s || wd_hit_s) begin
                        state_r    <= RC_DONE;
                        endop_r    <= ALL_CORES;
                        core_run_r <= NO_CORES;
                        all_done_r <= 1'b1;
                        busy_r     <= 1'b0;
                        timeout_r  <= ~all_halted_s;
                    end else begin
                        endop_r    <= halt_merge_s;
                        core_run_r <= ~halt_merge_s;
                    end
                end
                default: begin
                    state_r    <= RC_IDLE;
                    pc_load_r  <= 1'b0;
                    core_run_r <= NO_CORES;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_load      = pc_load_r;
    assign bus.pc_init      = current_PC_value;
    assign bus.core_run     = core_run_r;
    assign bus.endop_signal = endop_r;
    assign bus.all_done     = all_done_r;
    assign bus.busy         = busy_r;
    assign bus.timeout      = timeout_r;
    assign bus.cycle_count  = count_r;

endmodule

// File: tb/tb_core_run_control.sv
// Randomized bench for core_run_control: two instances (watchdog off / max_cycles=20) share
// stimulus and are checked against a per-run model derived from each core's halt cycle.
module tb_core_run_control;
    import core_run_control_pkg::*;

    localparam int WD = 20;

    logic       clk = 1'b0;
    logic       reset_s = 1'b1;
    logic       start_s = 1'b0;
    logic [1:0] halt_s  = 2'b00;

    int checks = 0;
    int errors = 0;
    int h[2];

    core_run_control_if #(.core_count(2), .reg_width(12), .cyc_width(16)) if_a ();
    core_run_control_if #(.core_count(2), .reg_width(12), .cyc_width(16)) if_b ();

    assign if_a.start     = start_s;
    assign if_a.core_halt = halt_s;
    assign if_b.start     = start_s;
    assign if_b.core_halt = halt_s;

    core_run_control #(.core_count(2), .reg_width(12), .current_PC_value(12'h000),
                       .cyc_width(16), .max_cycles(0))
        dut_a (.clk(clk), .reset(reset_s), .bus(if_a.slave));

    core_run_control #(.core_count(2), .reg_width(12), .current_PC_value(12'h000),
                       .cyc_width(16), .max_cycles(WD))
        dut_b (.clk(clk), .reset(reset_s), .bus(if_b.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k: -2 idle/reset, -1 LOAD, 0..fin RUN cycle k, >fin DONE.
    task automatic check_dut(input string nm, input int k, input int fin, input bit tmo_e,
                             input logic pl, input logic [1:0] cr, input logic [1:0] eo,
                             input logic ad, input logic bz, input logic tmo,
                             input logic [15:0] cnt);
        logic       pl_e, ad_e, bz_e, to_e;
        logic [1:0] cr_e, eo_e;
        int         cnt_e;
        pl_e = 1'b0; ad_e = 1'b0; bz_e = 1'b0; to_e = 1'b0;
        cr_e = 2'b00; eo_e = 2'b00; cnt_e = 0;
        if (k == -1) begin
            pl_e = 1'b1; bz_e = 1'b1;
        end else if (k >= 0 && k <= fin) begin
            bz_e = 1'b1; cnt_e = k;
            for (int i = 0; i < 2; i++) begin
                cr_e[i] = (h[i] >= k);
                eo_e[i] = (h[i] < k);
            end
        end else if (k > fin) begin
            eo_e = 2'b11; ad_e = 1'b1; to_e = tmo_e; cnt_e = fin + 1;
        end
        check($sformatf("%s_k%0d_pc_load", nm, k), 32'(pl), 32'(pl_e));
        check($sformatf("%s_k%0d_core_run", nm, k), 32'(cr), 32'(cr_e));
        check($sformatf("%s_k%0d_endop", nm, k), 32'(eo), 32'(eo_e));
        check($sformatf("%s_k%0d_all_done", nm, k), 32'(ad), 32'(ad_e));
        check($sformatf("%s_k%0d_busy", nm, k), 32'(bz), 32'(bz_e));
        check($sformatf("%s_k%0d_timeout", nm, k), 32'(tmo), 32'(to_e));
        check($sformatf("%s_k%0d_count", nm, k), 32'(cnt), 32'(cnt_e));
    endtask

    task automatic check_both(input int k, input int fa, input int fb, input bit tb);
        check_dut("a", k, fa, 1'b0, if_a.pc_load, if_a.core_run, if_a.endop_signal,
                  if_a.all_done, if_a.busy, if_a.timeout, if_a.cycle_count);
        check_dut("b", k, fb, tb, if_b.pc_load, if_b.core_run, if_b.endop_signal,
                  if_b.all_done, if_b.busy, if_b.timeout, if_b.cycle_count);
    endtask

    // One run: core i first halts in RUN cycle hi; abort_k >= 0 asserts reset in that cycle.
    task automatic do_run(input int h0, input int h1, input int abort_k);
        int  maxh, fa, fb, last;
        bit  tob;
        h[0] = h0; h[1] = h1;
        maxh = (h0 > h1) ? h0 : h1;
        fa   = maxh;
        tob  = (maxh > WD - 1);
        fb   = tob ? WD - 1 : maxh;
        last = fa + 1;

        start_s = 1'b1;
        halt_s  = 2'($urandom_range(0, 3));
        step();
        start_s = 1'b0;
        check_both(-1, fa, fb, tob);
        halt_s = 2'($urandom_range(0, 3));
        step();
        for (int k = 0; k <= last; k++) begin
            check_both(k, fa, fb, tob);
            if (k == abort_k) begin
                reset_s = 1'b1;
                halt_s  = 2'b00;
                step();
                check_both(-2, fa, fb, tob);
                reset_s = 1'b0;
                halt_s  = 2'b11;
                step();
                check_both(-2, fa, fb, tob);
                halt_s = 2'b00;
                return;
            end
            for (int i = 0; i < 2; i++)
                halt_s[i] = (k == h[i]) || (k > h[i] && $urandom_range(0, 1) == 1);
            start_s = (k <= fb) && ($urandom_range(0, 3) == 0);
            step();
            start_s = 1'b0;
        end
        halt_s = 2'b00;
    endtask

    initial begin
        int r0, r1;
        reset_s = 1'b1;
        repeat (3) step();
        reset_s = 1'b0;
        step();
        check_both(-2, 0, 0, 1'b0);
        check("pc_init", 32'(if_a.pc_init), 32'h0);

        do_run(5, 9, -1);
        do_run(7, 7, -1);
        do_run(3, 30, -1);
        do_run(0, 0, -1);
        do_run(2, 12, 6);

        for (int n = 0; n < 25; n++) begin
            r0 = $urandom_range(0, 30);
            r1 = $urandom_range(0, 30);
            if (r0 >= r1 && r0 == WD - 1) r0 = WD;
            if (r1 > r0 && r1 == WD - 1) r1 = WD;
            do_run(r0, r1, (n % 8 == 7) ? $urandom_range(0, 5) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
